// File: rtl/game_pkg.sv
// game_pkg: shared types and screen limits for the game pixel path.
// Holds scheduler state encoding, requester indices and job bundle.
package game_pkg;

  localparam int NUM_REQ  = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int IDX_W    = 2;

  localparam logic [X_W:0] MAX_X = (X_W+1)'(159);
  localparam logic [Y_W:0] MAX_Y = (Y_W+1)'(119);
  localparam logic [COLOUR_W-1:0] BG_COLOUR = '0;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t REQ_BALL   = 2'd0;
  localparam idx_t REQ_PADDLE = 2'd1;
  localparam idx_t REQ_BLOCK  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ERASE,
    DRAW,
    DONE
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]      new_x;
    logic [Y_W-1:0]      new_y;
    logic [X_W-1:0]      size_x;
    logic [Y_W-1:0]      size_y;
    logic [COLOUR_W-1:0] colour;
  } job_t;

  function automatic logic on_screen(
    logic [X_W:0] x,
    logic [Y_W:0] y
  );
    return (x <= MAX_X) && (y <= MAX_Y);
  endfunction

endpackage

// File: rtl/plot_scheduler_if.sv
// plot_scheduler_if: requester job bus plus VGA pixel port.
// master = requesters/adapter side, slave = the scheduler.
interface plot_scheduler_if;
  import game_pkg::*;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*X_W-1:0]      req_new_x;
  logic [NUM_REQ*Y_W-1:0]      req_new_y;
  logic [NUM_REQ*X_W-1:0]      req_old_x;
  logic [NUM_REQ*Y_W-1:0]      req_old_y;
  logic [NUM_REQ*X_W-1:0]      req_size_x;
  logic [NUM_REQ*Y_W-1:0]      req_size_y;
  logic [NUM_REQ*COLOUR_W-1:0] req_colour;
  logic [NUM_REQ-1:0]          ack;
  logic [X_W-1:0]              vga_x;
  logic [Y_W-1:0]              vga_y;
  logic [COLOUR_W-1:0]         vga_colour;
  logic                        vga_plot;
  logic                        busy;

  modport master (
    output req, req_new_x, req_new_y,
    output req_old_x, req_old_y,
    output req_size_x, req_size_y, req_colour,
    input  ack, vga_x, vga_y,
    input  vga_colour, vga_plot, busy
  );

  modport slave (
    input  req, req_new_x, req_new_y,
    input  req_old_x, req_old_y,
    input  req_size_x, req_size_y, req_colour,
    output ack, vga_x, vga_y,
    output vga_colour, vga_plot, busy
  );

endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: row-major walk of one rectangle, one pixel per step.
// nxt_x/nxt_y is the pixel held after this edge; last flags the end.
module rect_scanner
  import game_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  input  logic [X_W-1:0] size_x,
  input  logic [Y_W-1:0] size_y,
  output logic [X_W:0]   nxt_x,
  output logic [Y_W:0]   nxt_y,
  output logic           last
);

  logic [X_W:0] cx, org_x, end_x;
  logic [Y_W:0] cy, end_y;

  assign last = (cx == end_x) && (cy == end_y);

  // Next position: restart on load, else wrap x into the next row.
  always_comb begin
    nxt_x = cx;
    nxt_y = cy;
    if (load) begin
      nxt_x = {1'b0, base_x};
      nxt_y = {1'b0, base_y};
    end else if (step) begin
      if (cx == end_x) begin
        nxt_x = org_x;
        nxt_y = cy + (Y_W+1)'(1);
      end else begin
        nxt_x = cx + (X_W+1)'(1);
      end
    end
  end

  // Position and rectangle bounds; one extra bit so ends never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx    <= '0;
      cy    <= '0;
      org_x <= '0;
      end_x <= '0;
      end_y <= '0;
    end else begin
      cx <= nxt_x;
      cy <= nxt_y;
      if (load) begin
        org_x <= {1'b0, base_x};
        end_x <= {1'b0, base_x} + {1'b0, size_x}
               - (X_W+1)'(1);
        end_y <= {1'b0, base_y} + {1'b0, size_y}
               - (Y_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// plot_scheduler: arbitrates erase-then-draw jobs onto the pixel port.
// PLOT_SCHED_ROUND_ROBIN_EN: round-robin arbitration, else fixed priority.
module plot_scheduler
  import game_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  plot_scheduler_if.slave bus
);

  state_t state, state_nxt;
  idx_t   win_idx, arb_idx;
  job_t   job, sel;

  logic [X_W-1:0] sel_old_x, sc_bx, sc_sx;
  logic [Y_W-1:0] sel_old_y, sc_by, sc_sy;
  logic           sc_load, sc_step, sc_last, zero;
  logic [X_W:0]   sc_nxt_x;
  logic [Y_W:0]   sc_nxt_y;

  logic                plot_nxt, plot_q;
  logic [COLOUR_W-1:0] colour_nxt, colour_q;
  logic [NUM_REQ-1:0]  ack_nxt, ack_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;

`ifdef PLOT_SCHED_ROUND_ROBIN_EN
  idx_t ptr;

  function automatic idx_t rr_pick(
    logic [NUM_REQ-1:0] r,
    idx_t               p
  );
    idx_t w;
    logic hit;
    w   = p;
    hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && r[i] && idx_t'(i) >= p) begin
        hit = 1'b1;
        w   = idx_t'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && r[i]) begin
        hit = 1'b1;
        w   = idx_t'(i);
      end
    end
    return w;
  endfunction

  assign arb_idx = rr_pick(bus.req, ptr);

  // Search start moves just past the job being granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ptr <= '0;
    else if (state == GRANT)
      ptr <= (win_idx == idx_t'(NUM_REQ-1)) ? '0
           : win_idx + idx_t'(1);
  end
`else
  function automatic idx_t fp_pick(logic [NUM_REQ-1:0] r);
    idx_t w;
    w = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (r[i]) w = idx_t'(i);
    end
    return w;
  endfunction

  assign arb_idx = fp_pick(bus.req);
`endif

  // Winner's fields, straight from the packed request bus.
  always_comb begin
    sel_old_x  = bus.req_old_x[int'(win_idx)*X_W +: X_W];
    sel_old_y  = bus.req_old_y[int'(win_idx)*Y_W +: Y_W];
    sel.new_x  = bus.req_new_x[int'(win_idx)*X_W +: X_W];
    sel.new_y  = bus.req_new_y[int'(win_idx)*Y_W +: Y_W];
    sel.size_x = bus.req_size_x[int'(win_idx)*X_W +: X_W];
    sel.size_y = bus.req_size_y[int'(win_idx)*Y_W +: Y_W];
    sel.colour =
      bus.req_colour[int'(win_idx)*COLOUR_W +: COLOUR_W];
    zero = (sel.size_x == '0) || (sel.size_y == '0);
  end

  rect_scanner u_scan (
    .clk    (clk),
    .resetn (resetn),
    .load   (sc_load),
    .step   (sc_step),
    .base_x (sc_bx),
    .base_y (sc_by),
    .size_x (sc_sx),
    .size_y (sc_sy),
    .nxt_x  (sc_nxt_x),
    .nxt_y  (sc_nxt_y),
    .last   (sc_last)
  );

  // Next state plus scanner control and next pixel attributes.
  always_comb begin
    state_nxt  = state;
    sc_load    = 1'b0;
    sc_step    = 1'b0;
    sc_bx      = sel_old_x;
    sc_by      = sel_old_y;
    sc_sx      = sel.size_x;
    sc_sy      = sel.size_y;
    colour_nxt = BG_COLOUR;
    unique case (state)
      IDLE:
        if (|bus.req) state_nxt = GRANT;
      GRANT:
        if (zero) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ERASE;
          sc_load   = 1'b1;
        end
      ERASE:
        if (sc_last) begin
          state_nxt  = DRAW;
          sc_load    = 1'b1;
          sc_bx      = job.new_x;
          sc_by      = job.new_y;
          sc_sx      = job.size_x;
          sc_sy      = job.size_y;
          colour_nxt = job.colour;
        end else begin
          sc_step = 1'b1;
        end
      DRAW: begin
        colour_nxt = job.colour;
        if (sc_last) state_nxt = DONE;
        else         sc_step   = 1'b1;
      end
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
    plot_nxt = (state_nxt == ERASE || state_nxt == DRAW)
             && on_screen(sc_nxt_x, sc_nxt_y);
    ack_nxt  = (state_nxt == DONE)
             ? (NUM_REQ'(1) << win_idx) : '0;
  end

  // State, captured job and registered pixel/ack outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      win_idx  <= '0;
      job      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |bus.req) win_idx <= arb_idx;
      if (state == GRANT) job <= sel;
      x_q      <= sc_nxt_x[X_W-1:0];
      y_q      <= sc_nxt_y[Y_W-1:0];
      colour_q <= colour_nxt;
      plot_q   <= plot_nxt;
      ack_q    <= ack_nxt;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;
  assign bus.busy       = (state != IDLE);

endmodule
